// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one 16-bit ALU among NUM_REQ requesters, with one
// operation in flight, a multi-cycle multiply and a single registered response slot.
module alu_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [3*NUM_REQ-1:0]   req_opcode,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_result,
  output logic [1:0]             rsp_flags,
  output logic                   busy
);

  localparam int CNT_W = (MUL_LATENCY > 32'sd2) ? $clog2(MUL_LATENCY - 32'sd1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 32'sd2);
  localparam logic [IDW-1:0]   LAST_RST = IDW'(NUM_REQ - 32'sd1);
  localparam bit               MUL_MULTI = (MUL_LATENCY > 32'sd1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  logic [IDW-1:0]     last_grant_r;
  logic [IDW-1:0]     id_r;
  logic [2:0]         op_r;
  logic [15:0]        a_r;
  logic [15:0]        b_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDW-1:0]     grant_idx_s;
  logic               found_s;
  logic               accept_s;
  logic [2:0]         sel_op_s;
  logic [15:0]        sel_a_s;
  logic [15:0]        sel_b_s;
  logic [2:0]         alu_op_s;
  logic [15:0]        alu_a_s;
  logic [15:0]        alu_b_s;
  logic [33:0]        alu_s;

  // Returns {illegal, carry, result[31:0]}; operands are zero-extended to 32 bits.
  function automatic logic [33:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] ax;
    logic [31:0] bx;
    logic [31:0] res;
    logic        carry;
    logic        illegal;
    ax      = {16'h0000, a};
    bx      = {16'h0000, b};
    res     = 32'h0000_0000;
    carry   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        res   = ax + bx;
        carry = res[16];
      end
      OP_MUL: begin
        res   = ax * bx;
        carry = |res[31:16];
      end
      OP_SUB: begin
        res   = ax - bx;
        carry = (a < b);
      end
      OP_AND: res = ax & bx;
      OP_OR:  res = ax | bx;
      OP_XOR: res = ax ^ bx;
      OP_NOT: res = ~ax;
      default: begin
        res     = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
    return {illegal, carry, res};
  endfunction

  // Rotating priority scan starting just after the last granted requester.
  always_comb begin : rr_scan
    int             idx_v;
    logic [IDW-1:0] pos_v;
    logic           hit_v;
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    idx_v       = 0;
    pos_v       = '0;
    hit_v       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v          = int'(last_grant_r) + k;
      idx_v          = (idx_v >= NUM_REQ) ? (idx_v - NUM_REQ) : idx_v;
      pos_v          = IDW'(idx_v);
      hit_v          = req_valid[pos_v] & ~found_s;
      grant_s[pos_v] = grant_s[pos_v] | hit_v;
      grant_idx_s    = hit_v ? pos_v : grant_idx_s;
      found_s        = found_s | hit_v;
    end
  end

  // Grants are only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = ((state_r == IDLE) && !rst) ? grant_s : '0;
    accept_s  = |(req_valid & req_ready);
  end

  // AND-OR select of the granted requester's operands.
  always_comb begin
    sel_op_s = 3'b000;
    sel_a_s  = 16'h0000;
    sel_b_s  = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s = sel_op_s | (req_opcode[3*i +: 3] & {3{grant_s[i]}});
      sel_a_s  = sel_a_s  | (req_a[16*i +: 16]    & {16{grant_s[i]}});
      sel_b_s  = sel_b_s  | (req_b[16*i +: 16]    & {16{grant_s[i]}});
    end
  end

  // Single ALU: fed live inputs for direct completion, latched operands when leaving EXEC.
  always_comb begin
    alu_op_s = (state_r == EXEC) ? op_r : sel_op_s;
    alu_a_s  = (state_r == EXEC) ? a_r  : sel_a_s;
    alu_b_s  = (state_r == EXEC) ? b_r  : sel_b_s;
    alu_s    = alu_f(alu_op_s, alu_a_s, alu_b_s);
  end

  // Scheduler FSM with registered response slot and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_RST;
      id_r         <= '0;
      op_r         <= 3'b000;
      a_r          <= 16'h0000;
      b_r          <= 16'h0000;
      cnt_r        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= 32'h0000_0000;
      rsp_flags    <= 2'b00;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            last_grant_r <= grant_idx_s;
            id_r         <= grant_idx_s;
            op_r         <= sel_op_s;
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            busy         <= 1'b1;
            if ((sel_op_s == OP_MUL) && MUL_MULTI) begin
              state_r <= EXEC;
              cnt_r   <= CNT_LOAD;
            end else begin
              state_r                 <= DONE;
              rsp_valid               <= 1'b1;
              rsp_id                  <= grant_idx_s;
              {rsp_flags, rsp_result} <= alu_s;
            end
          end
        end
        EXEC: begin
          if (cnt_r == '0) begin
            state_r                 <= DONE;
            rsp_valid               <= 1'b1;
            rsp_id                  <= id_r;
            {rsp_flags, rsp_result} <= alu_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed vector table, reset corner cases and
// randomized traffic against a behavioural round-robin/ALU model.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_flags;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int model_last = 3;
  logic [2:0]  t_op [4];
  logic [15:0] t_a  [4];
  logic [15:0] t_b  [4];

  typedef struct {
    logic [3:0]  mask;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic [1:0]  flags;
    int          id;
    int          bp;
  } vec_t;

  vec_t vt [13];

  alu_rr_scheduler #(.NUM_REQ(4), .MUL_LATENCY(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic, {flags, result}.
  function automatic logic [33:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    longint av, bv, r;
    logic [1:0] fl;
    av = longint'(a);
    bv = longint'(b);
    fl = 2'b00;
    case (op)
      3'd0: begin r = av + bv; fl = {1'b0, r > 64'sd65535}; end
      3'd1: begin r = av * bv; fl = {1'b0, r > 64'sd65535}; end
      3'd2: begin
        r = av - bv;
        if (r < 0) r = r + 64'sd4294967296;
        fl = {1'b0, av < bv};
      end
      3'd3: r = av & bv;
      3'd4: r = av | bv;
      3'd5: r = av ^ bv;
      3'd6: r = 64'sd4294967295 - av;
      default: begin r = 0; fl = 2'b10; end
    endcase
    return {fl, r[31:0]};
  endfunction

  function automatic int pick(input logic [3:0] mask);
    int j;
    for (int k = 1; k <= 4; k++) begin
      j = (model_last + k) % 4;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  // One transaction; entered and left at posedge+1 with the DUT idle.
  task automatic xact(input logic [3:0] mask, input int bp, input int exp_id,
                      input logic [33:0] exp);
    int lat;
    int exp_lat;
    exp_lat = (t_op[exp_id] == 3'b001) ? 3 : 1;
    for (int i = 0; i < 4; i++) begin
      req_opcode[3*i +: 3] = t_op[i];
      req_a[16*i +: 16]    = t_a[i];
      req_b[16*i +: 16]    = t_b[i];
    end
    req_valid = mask;
    rsp_ready = (bp == 0);
    #1;
    check("grant", 64'(req_ready), 64'(4'b0001 << exp_id));
    @(posedge clk); #1;
    req_valid  = 4'h0;
    req_opcode = 12'($urandom);
    req_a      = {$urandom, $urandom};
    req_b      = {$urandom, $urandom};
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      check("busy_exec", 64'(busy), 64'd1);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_id", 64'(rsp_id), 64'(exp_id));
    check("result", {30'd0, rsp_flags, rsp_result}, {30'd0, exp});
    for (int k = 0; k < bp; k++) begin
      req_valid = 4'hF;
      #1;
      check("stall_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      check("stall_hold", {29'd0, rsp_valid, rsp_id, rsp_flags, rsp_result},
            {29'd0, 1'b1, 2'(exp_id), exp});
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_drop", {62'd0, rsp_valid, busy}, 64'd0);
  endtask

  initial begin
    logic [3:0] mask;
    int g;
    vt[0]  = '{4'hF, 3'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 2'b01, 0, 0};
    vt[1]  = '{4'hF, 3'd0, 16'h1234, 16'h1111, 32'h0000_2345, 2'b00, 1, 2};
    vt[2]  = '{4'hF, 3'd1, 16'h1234, 16'h0010, 32'h0001_2340, 2'b01, 2, 0};
    vt[3]  = '{4'hF, 3'd2, 16'h0001, 16'h0002, 32'hFFFF_FFFF, 2'b01, 3, 5};
    vt[4]  = '{4'hF, 3'd6, 16'h00FF, 16'h0000, 32'hFFFF_FF00, 2'b00, 0, 0};
    vt[5]  = '{4'hF, 3'd7, 16'h1234, 16'h5678, 32'h0000_0000, 2'b10, 1, 0};
    vt[6]  = '{4'hF, 3'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 2'b01, 2, 3};
    vt[7]  = '{4'hF, 3'd3, 16'hF0F0, 16'hFF00, 32'h0000_F000, 2'b00, 3, 0};
    vt[8]  = '{4'h5, 3'd4, 16'hF0F0, 16'h0F0F, 32'h0000_FFFF, 2'b00, 0, 0};
    vt[9]  = '{4'h5, 3'd5, 16'hAAAA, 16'hFFFF, 32'h0000_5555, 2'b00, 2, 1};
    vt[10] = '{4'h8, 3'd2, 16'h0005, 16'h0003, 32'h0000_0002, 2'b00, 3, 0};
    vt[11] = '{4'h3, 3'd1, 16'h00FF, 16'h0002, 32'h0000_01FE, 2'b00, 0, 0};
    vt[12] = '{4'h6, 3'd0, 16'h8000, 16'h8000, 32'h0001_0000, 2'b01, 1, 0};

    rst        = 1'b1;
    req_valid  = 4'hF;
    req_opcode = 12'h000;
    req_a      = 64'd0;
    req_b      = 64'd0;
    rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_outputs", {27'd0, rsp_valid, rsp_id, rsp_flags, rsp_result, busy}, 64'd0);
    rst       = 1'b0;
    req_valid = 4'h0;
    model_last = 3;

    // Directed table: rotation 0,1,2,3,... with all requesters valid, then partial masks.
    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < 4; i++) begin
        t_op[i] = vt[v].op;
        t_a[i]  = vt[v].a;
        t_b[i]  = vt[v].b;
      end
      xact(vt[v].mask, vt[v].bp, vt[v].id, {vt[v].flags, vt[v].res});
      model_last = vt[v].id;
    end

    // Reset while a multiply is in EXEC: no response, then req0 wins first.
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 3'd1; t_a[i] = 16'h00FF; t_b[i] = 16'h0003;
      req_opcode[3*i +: 3] = t_op[i];
      req_a[16*i +: 16]    = t_a[i];
      req_b[16*i +: 16]    = t_b[i];
    end
    req_valid = 4'b1000;
    #1;
    check("pre_rst_grant", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1;
    req_valid = 4'h0;
    check("exec_state", {62'd0, busy, rsp_valid}, 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_exec", {62'd0, busy, rsp_valid}, 64'd0);
    req_valid = 4'hF;
    #1;
    check("rst_hold_ready", 64'(req_ready), 64'd0);
    rst       = 1'b0;
    req_valid = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    model_last = 3;
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 3'd0; t_a[i] = 16'(16'h0100 + i); t_b[i] = 16'h0001;
    end
    xact(4'hF, 0, 0, model(t_op[0], t_a[0], t_b[0]));
    model_last = 0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        t_op[i] = 3'($urandom_range(0, 7));
        t_a[i]  = 16'($urandom);
        t_b[i]  = 16'($urandom);
      end
      g = pick(mask);
      xact(mask, int'($urandom_range(0, 3)), g, model(t_op[g], t_a[g], t_b[g]));
      model_last = g;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
